// File: rtl/div_pkg.sv
// Shared types and helpers for the divider issue controller.
package div_pkg;

    localparam int DIV_DW = 8;
    localparam logic [DIV_DW-1:0] DIV_ZERO_Q = {DIV_DW{1'b1}};

    // The flag bit only exists when the divide-by-zero feature is built.
    typedef struct packed {
        logic [DIV_DW-1:0] quotient;
        logic [DIV_DW-1:0] remainder;
`ifdef DIV_ISSUE_DZ_FLAG_EN
        logic              div_by_zero;
`endif
    } div_result_t;

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Handshake bundle: operand request, divider connection and result output.
interface div_issue_ctrl_if #(
    parameter int DATAWIDTH = 8
);
    logic                 s_valid;
    logic                 s_ready;
    logic [DATAWIDTH-1:0] s_dividend;
    logic [DATAWIDTH-1:0] s_divisor;
    logic                 div_i_valid;
    logic [DATAWIDTH-1:0] div_A;
    logic [DATAWIDTH-1:0] div_B;
    logic                 div_o_valid;
    logic [DATAWIDTH-1:0] div_Q;
    logic [DATAWIDTH-1:0] div_R;
    logic                 m_valid;
    logic                 m_ready;
    logic [DATAWIDTH-1:0] m_quotient;
    logic [DATAWIDTH-1:0] m_remainder;
    logic                 m_div_by_zero;

    modport master (
        output s_valid, s_dividend, s_divisor, m_ready,
        output div_o_valid, div_Q, div_R,
        input  s_ready, div_i_valid, div_A, div_B,
        input  m_valid, m_quotient, m_remainder, m_div_by_zero
    );

    modport slave (
        input  s_valid, s_dividend, s_divisor, m_ready,
        input  div_o_valid, div_Q, div_R,
        output s_ready, div_i_valid, div_A, div_B,
        output m_valid, m_quotient, m_remainder, m_div_by_zero
    );
endinterface

// File: rtl/div_issue_ctrl_chk.sv
// Protocol checks for the issue controller: divider latency and FIFO overflow.
module div_issue_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic div_o_valid,
    input logic vld_last,
    input logic push,
    input logic full
);
    a_latency: assert property (@(posedge clk) disable iff (rst) div_o_valid == vld_last)
        else $error("div_o_valid out of step with issue marker: DIV_LATENCY misconfigured");

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> !full)
        else $error("divider result pushed into a full result FIFO");
endmodule

// File: rtl/div_result_fifo.sv
// Result FIFO: synchronous write, combinational head read, pointers wrap modulo DEPTH.
module div_result_fifo
    import div_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = count_w(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic           pop,
    input  div_result_t    din,
    output div_result_t    dout,
    output logic [CW-1:0]  count,
    output logic           full,
    output logic           empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    div_result_t   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_s;
    logic          pop_s;

    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == {CW{1'b0}});
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;
    assign count  = count_r;
    assign dout   = mem_r[rd_ptr_r];

    // Storage array, no reset needed: reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/div_issue_ctrl.sv
// Ready/valid front-end and result buffer for a no-stall pipelined divider.
// Optional macro DIV_ISSUE_DZ_FLAG_EN adds a divide-by-zero flag per result.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int DATAWIDTH   = DIV_DW,
    parameter int DIV_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input logic             clk,
    input logic             rst,
    div_issue_ctrl_if.slave bus
);
    localparam int CW = count_w(FIFO_DEPTH);

    logic                   issue_s;
    logic                   pop_s;
    logic                   ready_r;
    logic [CW-1:0]          in_flight_r;
    logic [CW-1:0]          fifo_count_s;
    logic [CW:0]            credit_next_s;
    logic [DIV_LATENCY-1:0] vld_sr_r;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    div_result_t            push_data_s;
    div_result_t            head_s;

    assign issue_s         = bus.s_valid & ready_r;
    assign pop_s           = ~fifo_empty_s & bus.m_ready;
    assign bus.s_ready     = ready_r;
    assign bus.div_i_valid = issue_s;
    assign bus.div_A       = bus.s_dividend;
    assign bus.div_B       = bus.s_divisor;

    // A credit covers an op from issue until its result leaves the FIFO;
    // a divider completion just moves it from in-flight to buffered.
    assign credit_next_s = {1'b0, in_flight_r} + {1'b0, fifo_count_s}
                         + {{CW{1'b0}}, issue_s} - {{CW{1'b0}}, pop_s};

    // Credit tracking; s_ready is registered so it never sees s_valid/m_ready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r     <= 1'b0;
            in_flight_r <= {CW{1'b0}};
        end else begin
            ready_r <= (credit_next_s < (CW+1)'(FIFO_DEPTH));
            case ({issue_s, bus.div_o_valid})
                2'b10:   in_flight_r <= in_flight_r + CW'(1);
                2'b01:   in_flight_r <= in_flight_r - CW'(1);
                default: in_flight_r <= in_flight_r;
            endcase
        end
    end

    // Issue marker delayed by the divider depth, used to cross-check div_o_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr_r <= {DIV_LATENCY{1'b0}};
        end else begin
            vld_sr_r[0] <= issue_s;
            for (int i = 1; i < DIV_LATENCY; i++) begin
                vld_sr_r[i] <= vld_sr_r[i-1];
            end
        end
    end

    assign push_data_s.quotient  = bus.div_Q;
    assign push_data_s.remainder = bus.div_R;

`ifdef DIV_ISSUE_DZ_FLAG_EN
    logic [DIV_LATENCY-1:0] dz_sr_r;

    // Zero-divisor flag travels alongside the op through the divider latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dz_sr_r <= {DIV_LATENCY{1'b0}};
        end else begin
            dz_sr_r[0] <= issue_s & (bus.s_divisor == {DATAWIDTH{1'b0}});
            for (int i = 1; i < DIV_LATENCY; i++) begin
                dz_sr_r[i] <= dz_sr_r[i-1];
            end
        end
    end

    assign push_data_s.div_by_zero = dz_sr_r[DIV_LATENCY-1];
    assign bus.m_div_by_zero       = ~fifo_empty_s & head_s.div_by_zero;
`else
    assign bus.m_div_by_zero = 1'b0;
`endif

    div_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.div_o_valid),
        .pop   (pop_s),
        .din   (push_data_s),
        .dout  (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign bus.m_valid     = ~fifo_empty_s;
    assign bus.m_quotient  = fifo_empty_s ? {DATAWIDTH{1'b0}} : head_s.quotient;
    assign bus.m_remainder = fifo_empty_s ? {DATAWIDTH{1'b0}} : head_s.remainder;

    div_issue_ctrl_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .div_o_valid (bus.div_o_valid),
        .vld_last    (vld_sr_r[DIV_LATENCY-1]),
        .push        (bus.div_o_valid),
        .full        (fifo_full_s)
    );
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural 2-stage divider and a result scoreboard.
`timescale 1ns/1ps
module tb_div_issue_ctrl;
    import div_pkg::*;

    localparam int DW    = 8;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
`ifdef DIV_ISSUE_DZ_FLAG_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic last_hs;
    exp_t sb[$];

    always #5 clk = ~clk;

    div_issue_ctrl_if #(.DATAWIDTH(DW)) bus();

    div_issue_ctrl #(
        .DATAWIDTH   (DW),
        .DIV_LATENCY (LAT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural stand-in for the pipelined array divider (two stages, shares clk/rst).
    logic          v1, v2;
    logic [DW-1:0] a1, b1, q2, r2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0; v2 <= 1'b0;
            a1 <= '0; b1 <= '0; q2 <= '0; r2 <= '0;
        end else begin
            v1 <= bus.div_i_valid;
            a1 <= bus.div_A;
            b1 <= bus.div_B;
            v2 <= v1;
            q2 <= (b1 == 8'd0) ? DIV_ZERO_Q : a1 / b1;
            r2 <= (b1 == 8'd0) ? a1 : a1 % b1;
        end
    end
    assign bus.div_o_valid = v2;
    assign bus.div_Q       = q2;
    assign bus.div_R       = r2;

    function automatic exp_t ref_div(input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.q = 8'hFF; e.r = a; e.dz = DZ_EN;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One clock: record handshakes and result pops against the scoreboard, then advance.
    task automatic tick();
        exp_t e;
        last_hs = bus.s_valid && bus.s_ready;
        if (bus.m_valid && bus.m_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_q",  bus.m_quotient,    e.q);
                chk("sb_r",  bus.m_remainder,   e.r);
                chk("sb_dz", bus.m_div_by_zero, e.dz);
            end
        end
        if (last_hs) sb.push_back(ref_div(bus.s_dividend, bus.s_divisor));
        @(posedge clk); #1;
    endtask

    task automatic send_one(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] eq, input logic [DW-1:0] er, input logic edz);
        int n;
        bus.m_ready = 1'b1; bus.s_valid = 1'b1; bus.s_dividend = a; bus.s_divisor = b;
        n = 0;
        do begin tick(); n++; end while (!last_hs && n < 10);
        chk({tag, "_accept"}, 32'(last_hs), 32'd1);
        bus.s_valid = 1'b0;
        n = 1;
        while (!bus.m_valid && n < 10) begin tick(); n++; end
        chk({tag, "_latency"}, 32'(n), 32'(LAT + 1));
        chk({tag, "_q"},  bus.m_quotient,    eq);
        chk({tag, "_r"},  bus.m_remainder,   er);
        chk({tag, "_dz"}, bus.m_div_by_zero, edz);
        tick();
        chk({tag, "_valid_after"}, bus.m_valid, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] pa [6];
        logic [DW-1:0] pb [6];
        int idx, cyc, sent, lost_ready, mv_seen;
        logic stayed;

        pa = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
        pb = '{8'd3,  8'd6,  8'd7,  8'd9,  8'd11, 8'd13};
        bus.s_valid = 1'b0; bus.s_dividend = '0; bus.s_divisor = '0; bus.m_ready = 1'b0;

        // Reset state
        @(posedge clk); #1;
        chk("rst_s_ready", bus.s_ready, 1'b0);
        chk("rst_m_valid", bus.m_valid, 1'b0);
        chk("rst_m_q",     bus.m_quotient, 8'd0);
        chk("rst_m_r",     bus.m_remainder, 8'd0);
        chk("rst_m_dz",    bus.m_div_by_zero, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_s_ready", bus.s_ready, 1'b1);

        // 1: basic division, pass-through and latency
        bus.s_valid = 1'b1; bus.s_dividend = 8'd100; bus.s_divisor = 8'd7; #1;
        chk("pass_i_valid", bus.div_i_valid, 1'b1);
        chk("pass_A", bus.div_A, 8'd100);
        chk("pass_B", bus.div_B, 8'd7);
        send_one("t1", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);

        // 2: backpressure fill, then drain in order
        bus.m_ready = 1'b0; idx = 0; stayed = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bus.s_valid = (idx < 6);
            bus.s_dividend = pa[idx % 6]; bus.s_divisor = pb[idx % 6];
            tick();
            if (last_hs) idx++;
            if (c >= 4 && bus.s_ready) stayed = 1'b0;
        end
        chk("bp_accepted", 32'(idx), 32'd4);
        chk("bp_ready_low", bus.s_ready, 1'b0);
        chk("bp_stayed_low", stayed, 1'b1);
        bus.m_ready = 1'b1;
        cyc = 0;
        while (!(idx == 6 && sb.size() == 0 && !bus.m_valid) && cyc < 40) begin
            bus.s_valid = (idx < 6);
            bus.s_dividend = pa[idx % 6]; bus.s_divisor = pb[idx % 6];
            tick();
            if (last_hs) idx++;
            cyc++;
        end
        chk("bp_all_accepted", 32'(idx), 32'd6);
        chk("bp_drained", 32'(sb.size()), 32'd0);
        bus.s_valid = 1'b0;

        // 3 and 4: divide by zero and boundaries
        send_one("t3_dz",  8'h5A, 8'd0,   8'hFF,  8'h5A, DZ_EN);
        send_one("t4_255", 8'd255, 8'd1,  8'd255, 8'd0,  1'b0);
        send_one("t4_3",   8'd3,  8'd200, 8'd0,   8'd3,  1'b0);
        send_one("t4_0",   8'd0,  8'd5,   8'd0,   8'd0,  1'b0);

        // 5: back-to-back random traffic, then random backpressure
        bus.m_ready = 1'b1; sent = 0; cyc = 0; lost_ready = 0;
        while (sent < 100 && cyc < 300) begin
            bus.s_valid = 1'b1;
            bus.s_dividend = 8'($urandom);
            bus.s_divisor  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            tick();
            if (last_hs) sent++;
            if (!bus.s_ready) lost_ready++;
            cyc++;
        end
        chk("b2b_sent", 32'(sent), 32'd100);
        chk("b2b_ready_never_low", 32'(lost_ready), 32'd0);
        for (int c = 0; c < 200; c++) begin
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.m_ready = 1'($urandom_range(0, 1));
            bus.s_dividend = 8'($urandom);
            bus.s_divisor  = 8'($urandom_range(0, 40));
            tick();
        end
        bus.s_valid = 1'b0; bus.m_ready = 1'b1; cyc = 0;
        while ((sb.size() != 0 || bus.m_valid) && cyc < 20) begin tick(); cyc++; end
        chk("rand_drained", 32'(sb.size()), 32'd0);

        // 6: reset with results both buffered and in flight
        bus.m_ready = 1'b0; sent = 0; cyc = 0;
        while (sent < 4 && cyc < 20) begin
            bus.s_valid = 1'b1; bus.s_dividend = 8'($urandom); bus.s_divisor = 8'($urandom_range(1, 255));
            tick();
            if (last_hs) sent++;
            cyc++;
        end
        bus.s_valid = 1'b0;
        chk("mid_m_valid_before", bus.m_valid, 1'b1);
        rst = 1'b1; #1;
        chk("mid_rst_m_valid", bus.m_valid, 1'b0);
        chk("mid_rst_s_ready", bus.s_ready, 1'b0);
        chk("mid_rst_m_q", bus.m_quotient, 8'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_post_s_ready", bus.s_ready, 1'b1);
        bus.m_ready = 1'b1; mv_seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.m_valid) mv_seen++;
            tick();
        end
        chk("mid_no_stale", 32'(mv_seen), 32'd0);
        send_one("t6_after", 8'd77, 8'd8, 8'd9, 8'd5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
